// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, 1-cycle imem request/response, 2-entry instruction queue to decode.
// Taken branches and jumps redirect the PC and flush the queue and any response still in flight.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [1:0]      pc_src,
    input  logic            br_cond,
    input  logic [XLEN-1:0] target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    input  logic            id_ready
);
    logic [XLEN-1:0] fetch_pc_q;
    logic [31:0]     instr_q [2];
    logic [XLEN-1:0] pc_q [2];
    logic            head_q;
    logic [1:0]      count_q;
    logic            inflight_q;
    logic            drop_q;
    logic            redir;
    logic            pop;
    logic            push;
    logic            tail;
    logic [2:0]      occ;

    assign redir    = redirect_valid & ((pc_src == 2'b01 & br_cond) | pc_src == 2'b10);
    assign if_valid = count_q != 2'd0;
    assign pop      = if_valid & id_ready;
    assign push     = imem_rvalid & inflight_q & !drop_q & !redir;
    assign tail     = head_q ^ count_q[0];
    // Slots that will be taken once this cycle's pop and any in-flight response settle.
    assign occ       = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign imem_req  = rst_n & !redir & (occ < 3'(QDEPTH));
    assign imem_addr = fetch_pc_q;

    assign if_instr    = if_valid ? instr_q[head_q] : '0;
    assign if_pc       = if_valid ? pc_q[head_q] : '0;
    assign if_pc_plus4 = if_valid ? pc_q[head_q] + XLEN'(4) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            head_q     <= 1'b0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
        end else begin
            inflight_q <= imem_req;
            drop_q     <= redir & inflight_q;
            if (redir) begin
                fetch_pc_q <= target & ~XLEN'(3);
                count_q    <= '0;
            end else begin
                if (imem_req)
                    fetch_pc_q <= fetch_pc_q + XLEN'(4);
                // An in-flight response always belongs to the word just below fetch_pc.
                if (push) begin
                    instr_q[tail] <= imem_rdata;
                    pc_q[tail]    <= fetch_pc_q - XLEN'(4);
                end
                if (pop)
                    head_q <= ~head_q;
                count_q <= count_q + 2'(push) - 2'(pop);
            end
        end
    end
endmodule
